// File: rtl/axi_lite_slave_ram.sv
`timescale 1ns/1ps
// AXI4-Lite word RAM responder; one write and one read outstanding, read and write paths independent.
// Latency: AW+W both held -> commit and B on the next edge; AR handshake -> R valid after that same edge.
// Backpressure: AW/W holding registers drop ready while full; B and R are held until bready/rready.
module axi_lite_slave_ram #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_awaddr,
    input  logic [2:0]  s_awprot,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic [2:0]  s_arprot,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready
);
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    rstate_t rstate, rstate_nxt;

    logic [31:0]   mem [DEPTH];
    logic          init_done;
    logic          aw_full, aw_ok;
    logic [IW-1:0] aw_idx;
    logic          w_full;
    logic [31:0]   w_dat;
    logic [3:0]    w_strb;

    logic [31:0]   aw_off, ar_off;
    logic          aw_in_range, ar_in_range;
    logic          aw_hs, w_hs, ar_hs, commit;
    logic          unused_bits;

    assign aw_off      = s_awaddr - BASE_ADDR;
    assign ar_off      = s_araddr - BASE_ADDR;
    assign aw_in_range = ({1'b0, s_awaddr} >= {1'b0, BASE_ADDR}) && ({1'b0, s_awaddr} < LIMIT);
    assign ar_in_range = ({1'b0, s_araddr} >= {1'b0, BASE_ADDR}) && ({1'b0, s_araddr} < LIMIT);
    assign unused_bits = ^{s_awprot, s_arprot, aw_off, ar_off};

    assign s_awready = init_done && !aw_full;
    assign s_wready  = init_done && !w_full;
    assign s_arready = init_done && (rstate == R_IDLE);
    assign s_rvalid  = (rstate == R_DATA);

    assign aw_hs  = s_awvalid && s_awready;
    assign w_hs   = s_wvalid && s_wready;
    assign ar_hs  = s_arvalid && s_arready;
    // A new write may be captured while B is pending, but it only commits once B has gone.
    assign commit = aw_full && w_full && !s_bvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
            aw_full   <= 1'b0;
            aw_ok     <= 1'b0;
            aw_idx    <= '0;
            w_full    <= 1'b0;
            w_dat     <= '0;
            w_strb    <= '0;
            s_bvalid  <= 1'b0;
            s_bresp   <= OKAY;
        end else begin
            init_done <= 1'b1;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= aw_off[IW+1:2];
                aw_ok   <= aw_in_range;
            end else if (commit) begin
                aw_full <= 1'b0;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_dat  <= s_wdata;
                w_strb <= s_wstrb;
            end else if (commit) begin
                w_full <= 1'b0;
            end
            if (commit) begin
                s_bvalid <= 1'b1;
                s_bresp  <= aw_ok ? OKAY : SLVERR;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    // Reset clears the full flags asynchronously, so commit cannot fire while rst_n is low.
    always_ff @(posedge clk) begin
        if (commit && aw_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_dat[8*i +: 8];
            end
        end
    end

    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_IDLE: if (ar_hs) rstate_nxt = R_DATA;
            R_DATA: if (s_rready) rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate  <= R_IDLE;
            s_rdata <= '0;
            s_rresp <= OKAY;
        end else begin
            rstate <= rstate_nxt;
            // Non-blocking RAM update means a same-edge commit is not visible here.
            if (ar_hs) begin
                s_rdata <= ar_in_range ? mem[ar_off[IW+1:2]] : '0;
                s_rresp <= ar_in_range ? OKAY : SLVERR;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_ram.sv
`timescale 1ns/1ps
// Directed bench for axi_lite_slave_ram: reset release, strobes, B backpressure,
// address decode errors and a same-edge write/read collision.
module tb_axi_lite_slave_ram;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_lite_slave_ram #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done;
        int n, m;
        @(negedge clk);
        s_awaddr = addr; s_awvalid = 1'b1;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
        aw_done = 0; w_done = 0; n = 0; m = 0;
        while (!(aw_done && w_done) && n < 50) begin
            if (s_awvalid && s_awready) aw_done = 1;
            if (s_wvalid && s_wready) w_done = 1;
            @(posedge clk); #1;
            if (aw_done) s_awvalid = 1'b0;
            if (w_done) s_wvalid = 1'b0;
            @(negedge clk);
            n++;
        end
        s_bready = 1'b1;
        while (!s_bvalid && m < 50) begin
            @(negedge clk);
            m++;
        end
        resp = s_bresp;
        tests++;
        if (n >= 50 || m >= 50) begin
            fails++;
            $display("FAIL write_timeout addr=%h got aw/w/b waits %0d/%0d, need < 50", addr, n, m);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int n;
        @(negedge clk);
        s_araddr = addr; s_arvalid = 1'b1; n = 0;
        while (!s_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!s_rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        data = s_rdata; resp = s_rresp;
        tests++;
        if (n >= 50 || lat >= 50) begin
            fails++;
            $display("FAIL read_timeout addr=%h got ar/r waits %0d/%0d, need < 50", addr, n, lat);
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
            fails++;
            $display("FAIL reset_hs got %b need 00000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        tests++;
        if ({s_bresp, s_rresp, s_rdata} !== 36'h0) begin
            fails++;
            $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h need 0", s_bresp, s_rresp, s_rdata);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            fails++;
            $display("FAIL ready_before_first_edge got %b need 000", {s_awready, s_wready, s_arready});
        end
        @(posedge clk); #1;
        tests++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b11100) begin
            fails++;
            $display("FAIL ready_after_init got %b need 11100", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
    endtask

    task automatic test_same_cycle;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        @(negedge clk);
        s_awaddr = 32'h10; s_awvalid = 1'b1; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tests++;
        if ({s_awready, s_wready} !== 2'b11) begin
            fails++;
            $display("FAIL aw_w_ready got %b need 11", {s_awready, s_wready});
        end
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        tests++;
        if (s_bvalid !== 1'b0) begin
            fails++;
            $display("FAIL b_early got bvalid=%b need 0", s_bvalid);
        end
        @(negedge clk);
        tests++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
            fails++;
            $display("FAIL b_latency got bvalid=%b bresp=%b need 1/00", s_bvalid, s_bresp);
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        @(negedge clk);
        tests++;
        if (s_bvalid !== 1'b0) begin
            fails++;
            $display("FAIL b_clear got bvalid=%b need 0", s_bvalid);
        end
        axi_read(32'h10, d, r, lat);
        tests++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b00 || lat !== 0) begin
            fails++;
            $display("FAIL read_10 got %h/%b lat %0d need deadbeef/00 lat 0", d, r, lat);
        end
    endtask

    task automatic test_strobes;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        axi_write(32'h20, 32'h1122_3344, 4'hF, r);
        axi_write(32'h20, 32'hAABB_CCDD, 4'b0101, r);
        axi_read(32'h20, d, r, lat);
        tests++;
        if (d !== 32'h11BB_33DD || r !== 2'b00) begin
            fails++;
            $display("FAIL strb_0101 got %h/%b need 11bb33dd/00", d, r);
        end
        axi_write(32'h22, 32'h5566_7788, 4'b1010, r);
        axi_read(32'h23, d, r, lat);
        tests++;
        if (d !== 32'h55BB_77DD) begin
            fails++;
            $display("FAIL strb_1010 got %h need 55bb77dd", d);
        end
        axi_write(32'h20, 32'hFFFF_FFFF, 4'b0000, r);
        tests++;
        if (r !== 2'b00) begin
            fails++;
            $display("FAIL strb_0_resp got %b need 00", r);
        end
        axi_read(32'h20, d, r, lat);
        tests++;
        if (d !== 32'h55BB_77DD) begin
            fails++;
            $display("FAIL strb_0_data got %h need 55bb77dd", d);
        end
    endtask

    task automatic test_w_before_aw;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        @(negedge clk);
        s_wdata = 32'h0000_0A0A; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_wvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (s_wready !== 1'b0 || s_bvalid !== 1'b0) begin
                fails++;
                $display("FAIL w_held got wready=%b bvalid=%b need 0/0", s_wready, s_bvalid);
            end
        end
        s_awaddr = 32'h40; s_awvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        @(negedge clk);
        tests++;
        if (s_bvalid !== 1'b0) begin
            fails++;
            $display("FAIL b_early2 got bvalid=%b need 0", s_bvalid);
        end
        @(negedge clk);
        s_awaddr = 32'h40; s_awvalid = 1'b1; s_wdata = 32'h0000_0B0B; s_wvalid = 1'b1;
        tests++;
        if ({s_awready, s_wready} !== 2'b11) begin
            fails++;
            $display("FAIL capture_during_b got %b need 11", {s_awready, s_wready});
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
                fails++;
                $display("FAIL b_stable cycle %0d got %b/%b need 1/00", i, s_bvalid, s_bresp);
            end
            if (i == 1) begin
                tests++;
                if ({s_awready, s_wready} !== 2'b00) begin
                    fails++;
                    $display("FAIL second_held got %b need 00", {s_awready, s_wready});
                end
            end
            @(posedge clk); #1;
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            @(negedge clk);
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        @(negedge clk);
        tests++;
        if (s_bvalid !== 1'b0) begin
            fails++;
            $display("FAIL b_gap got bvalid=%b need 0", s_bvalid);
        end
        @(negedge clk);
        tests++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
            fails++;
            $display("FAIL b_second got %b/%b need 1/00", s_bvalid, s_bresp);
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        axi_read(32'h40, d, r, lat);
        tests++;
        if (d !== 32'h0000_0B0B) begin
            fails++;
            $display("FAIL read_40 got %h need 00000b0b", d);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        axi_write(32'h0, 32'hCAFE_F00D, 4'hF, r);
        axi_write(32'h1000, 32'hFFFF_FFFF, 4'hF, r);
        tests++;
        if (r !== 2'b10) begin
            fails++;
            $display("FAIL oor_bresp got %b need 10", r);
        end
        axi_read(32'h0, d, r, lat);
        tests++;
        if (d !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL oor_no_alias got %h need cafef00d", d);
        end
        axi_write(32'hFFC, 32'h1234_5678, 4'hF, r);
        tests++;
        if (r !== 2'b00) begin
            fails++;
            $display("FAIL last_word_bresp got %b need 00", r);
        end
        axi_read(32'hFFC, d, r, lat);
        tests++;
        if (d !== 32'h1234_5678 || r !== 2'b00) begin
            fails++;
            $display("FAIL last_word_read got %h/%b need 12345678/00", d, r);
        end
        axi_read(32'h1000, d, r, lat);
        tests++;
        if (d !== 32'h0 || r !== 2'b10) begin
            fails++;
            $display("FAIL oor_read got %h/%b need 00000000/10", d, r);
        end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        axi_write(32'h30, 32'h1, 4'hF, r);
        @(negedge clk);
        s_awaddr = 32'h30; s_awvalid = 1'b1; s_wdata = 32'h2; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        s_araddr = 32'h30; s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (s_rvalid !== 1'b1 || s_rdata !== 32'h1 || s_rresp !== 2'b00) begin
                fails++;
                $display("FAIL collision_old cycle %0d got %b/%h/%b need 1/00000001/00", i, s_rvalid, s_rdata, s_rresp);
            end
        end
        tests++;
        if (s_bvalid !== 1'b1) begin
            fails++;
            $display("FAIL collision_b got bvalid=%b need 1", s_bvalid);
        end
        s_rready = 1'b1; s_bready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0; s_bready = 1'b0;
        axi_read(32'h30, d, r, lat);
        tests++;
        if (d !== 32'h2) begin
            fails++;
            $display("FAIL collision_new got %h need 00000002", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_same_cycle();
        test_strobes();
        test_w_before_aw();
        test_out_of_range();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
